// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default bus widths for the fetch/data memory-port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data has priority; a saturating streak counter bounds fetch starvation.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_q, state_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              i_valid_q, i_valid_d;
    logic              d_valid_q, d_valid_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              busy_q, busy_d;

    // A requester seeing its valid this cycle still holds a stale req; ignore it.
    logic i_req_eff, d_req_eff, starved;
    assign i_req_eff = i_req & ~i_valid_q;
    assign d_req_eff = d_req & ~d_valid_q;
    assign starved   = (streak_q >= SW'(STARVE_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            streak_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            streak_q  <= streak_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_valid_d = 1'b0;
        d_valid_d = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        streak_d  = streak_q;

        case (state_q)
            IDLE: begin
                if (d_req_eff && (!starved || !i_req_eff)) begin
                    state_d   = D_BUSY;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    if (!i_req_eff) begin
                        streak_d = '0;
                    end else if (!starved) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (i_req_eff) begin
                    state_d  = I_BUSY;
                    m_req_d  = 1'b1;
                    m_we_d   = 1'b0;
                    m_addr_d = i_addr;
                    streak_d = '0;
                end
            end
            D_BUSY: begin
                if (m_ready) begin
                    state_d   = IDLE;
                    m_req_d   = 1'b0;
                    m_we_d    = 1'b0;
                    d_valid_d = 1'b1;
                    if (!m_we_q) begin
                        d_rdata_d = m_rdata;
                    end
                end
            end
            I_BUSY: begin
                if (m_ready) begin
                    state_d   = IDLE;
                    m_req_d   = 1'b0;
                    i_valid_d = 1'b1;
                    i_rdata_d = m_rdata;
                end
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
                m_we_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_valid = i_valid_q;
    assign d_valid = d_valid_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = busy_q;

endmodule
